l1i_cache_sa: RTL and testbench
===============================

# l1i_cache_sa

Parametrised set-associative L1 instruction cache: successor to the direct-mapped I-cache, with configurable ways, sets and line length, LRU replacement, a whole-cache flush for fence.i, and bus-error reporting. It sits between the fetch stage and the TileLink-UL crossbar. On a miss it refills one line using single-word Get requests on the A channel and AccessAckData responses on the D channel. Tag, valid and data storage are flops, so hits return in the same cycle.

## Interface
- WAYS, 2: associativity, 1 or 2.
- SETS, 16: sets per way, power of two, ≥2.
- LINE_WORDS, 4: 32-bit words per line, power of two, ≥2.
- SOURCE_ID, 5'd0: TileLink source driven on A; D beats with another source are ignored.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- Core_CacheEn  in  1  fetch request valid.
- Core_CacheAddr  in  32  fetch byte address; bits [1:0] are ignored.
- Core_CacheFlush  in  1  invalidate the whole cache (fence.i).
- Cache_DataRd  out  32  instruction word; 0 when not delivering.
- Cache_StallReq  out  1  fetch must hold its address.
- Cache_Error  out  1  one-cycle access-fault completion.
- Bus_aBitsReady  in  1; Bus_aBitsValid  out  1; Bus_aBitsAddress  out  32; Bus_aBitsOpcode  out  3; Bus_aBitsSize  out  4; Bus_aBitsMask  out  4; Bus_aBitsData  out  32; Bus_aBitsParam  out  3; Bus_aBitsSource  out  5; Bus_aBitsCorrupt  out  1.
- Bus_dBitsReady  out  1; Bus_dBitsValid  in  1; Bus_dBitsOpcode  in  3; Bus_dBitsData  in  32; Bus_dBitsSource  in  5; Bus_dBitsDennied  in  1; Bus_dBitsCorrupt  in  1.

## Operation
- Address split: word offset = [2+WB-1:2] with WB = log2(LINE_WORDS); index = next log2(SETS) bits; tag = remaining upper bits.
- States:
  - IDLE: lookup.
  - REQ: A beat outstanding.
  - RESP: waiting for the D beat.
  - FILL: install the line.
- IDLE, Core_CacheEn=1, hit in any way: Cache_DataRd = word, stall 0, LRU updated. LRU is one bit per set, pointing at the way not just used; it is unused when WAYS=1.
- IDLE, Core_CacheEn=1, miss:
  - Stall 1 combinationally.
  - Latch the line address; victim = lowest-numbered invalid way, else the LRU way.
  - Clear the beat counter and error flag; go to REQ.
- REQ: A channel constants:
  - Valid 1, opcode 4 (Get), size 2, mask 4'hF, data 0, param 0, corrupt 0, source SOURCE_ID.
  - Address = {latched tag, index, beat, 2'b00}.
  - Valid is held until Bus_aBitsReady; then go to RESP.
- RESP: Bus_dBitsReady=1.
  - A D beat is accepted when valid, opcode 1 and source match. Its data goes to a line buffer at [beat]; denied|corrupt ORs into the error flag.
  - After the accept, beat increments. If beat was LINE_WORDS-1, go to FILL; else go to REQ.
  - Non-matching D beats are consumed with no effect.
- FILL: one cycle.
  - No error: write the buffer, tag and valid into the victim way; set LRU. Stall stays 1, so the retry hits in the next IDLE cycle.
  - Error: nothing written; Cache_Error=1, Cache_StallReq=0, Cache_DataRd=0 for this cycle only.
- Flush:
  - In IDLE: clear all valid bits and LRU at the clock edge. Stall is 1 that cycle and lookup is suppressed.
  - During REQ/RESP/FILL: latched as pending. Applied in the IDLE cycle after FILL, so the filled line is also invalidated.
- Core_CacheEn=0 in IDLE: stall 0, data 0, no state change.
- An address change during a refill does not abort it; the new address is looked up back in IDLE.
- At most one A beat is outstanding; the A and D handshakes never overlap.

## Timing
- Reset values:
  - State IDLE; all valid and LRU bits 0.
  - Bus_aBitsValid=0, Bus_dBitsReady=0, Cache_Error=0.
  - Cache_StallReq=0 with En=0; Cache_DataRd=0.
- Reset mid-refill aborts immediately: no line is installed and the pending flush is cleared. The bus is reset together with this block.
- Hit latency: 0 cycles (combinational from registered arrays).
- Miss, zero-wait bus (aReady=1; D valid the cycle after the A handshake): stall is held for 1 + 2·LINE_WORDS + 1 cycles (10 for LINE_WORDS=4), and the hit occurs in the next cycle.
- A-channel fields other than valid are stable while valid=1 and ready=0.
- Cache_Error pulse width is exactly 1 cycle.

## Test plan
- Cold miss at 0x0000_0040, bus returns 0x11,0x22,0x33,0x44, zero-wait:
  - A addresses 0x40, 0x44, 0x48, 0x4C.
  - Stall 10 cycles, then data 0x22 for address 0x44.
- Two-way conflict, SETS=16, LINE_WORDS=4:
  - Fill 0x000, 0x100, hit 0x000, then miss 0x200.
  - 0x100's way is evicted; 0x000 still hits, 0x100 misses.
- Flush:
  - Flush in IDLE: the next fetch of 0x40 misses.
  - Flush asserted during RESP: the line is filled and then invalidated, and a refetch misses.
- D beat 2 with corrupt=1:
  - All 4 beats are collected; FILL asserts Cache_Error=1 for 1 cycle.
  - Nothing is installed; a retry misses again.
- Backpressure and D filtering:
  - Bus_aBitsReady held 0 for 3 cycles: valid and address stay stable.
  - A D beat with source 5'd7 is ignored and the beat count is unchanged.
- rst pulse during beat 1:
  - Outputs return to reset values asynchronously.
  - A later fetch of the same address misses.

Source files
------------

// File: rtl/l1i_cache_sa.sv
// Set-associative L1 instruction cache: flop-based tag/data arrays, LRU replacement,
// fence.i flush and line refill via single-word TileLink-UL Get requests.
module l1i_cache_sa #(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [4:0]  SOURCE_ID  = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Core_CacheEn,
    input  logic [31:0] Core_CacheAddr,
    input  logic        Core_CacheFlush,
    output logic [31:0] Cache_DataRd,
    output logic        Cache_StallReq,
    output logic        Cache_Error,
    input  logic        Bus_aBitsReady,
    output logic        Bus_aBitsValid,
    output logic [31:0] Bus_aBitsAddress,
    output logic [2:0]  Bus_aBitsOpcode,
    output logic [3:0]  Bus_aBitsSize,
    output logic [3:0]  Bus_aBitsMask,
    output logic [31:0] Bus_aBitsData,
    output logic [2:0]  Bus_aBitsParam,
    output logic [4:0]  Bus_aBitsSource,
    output logic        Bus_aBitsCorrupt,
    output logic        Bus_dBitsReady,
    input  logic        Bus_dBitsValid,
    input  logic [2:0]  Bus_dBitsOpcode,
    input  logic [31:0] Bus_dBitsData,
    input  logic [4:0]  Bus_dBitsSource,
    input  logic        Bus_dBitsDennied,
    input  logic        Bus_dBitsCorrupt
);
    localparam int unsigned WordW = $clog2(LINE_WORDS);
    localparam int unsigned IdxW  = $clog2(SETS);
    localparam int unsigned TagW  = 32 - 2 - WordW - IdxW;
    localparam int unsigned LineW = 30 - WordW;
    localparam logic [WordW-1:0] LastBeat = WordW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StFill
    } state_e;

    // Storage
    logic [SETS-1:0]  r_valid [WAYS];
    logic [TagW-1:0]  r_tag   [WAYS][SETS];
    logic [31:0]      r_data  [WAYS][SETS][LINE_WORDS];
    logic [SETS-1:0]  r_lru;
    logic [31:0]      r_buf   [LINE_WORDS];

    // Refill control
    state_e           r_state;
    state_e           w_state_d;
    logic [LineW-1:0] r_line_addr;
    logic [WordW-1:0] r_beat;
    logic             r_err;
    logic             r_victim;
    logic             r_flush_pend;

    logic [WordW-1:0] w_word;
    logic [IdxW-1:0]  w_idx;
    logic [TagW-1:0]  w_tag;
    logic [IdxW-1:0]  w_fill_idx;
    logic [TagW-1:0]  w_fill_tag;
    logic             w_hit;
    logic             w_hit_way;
    logic [31:0]      w_hit_word;
    logic             w_victim;
    logic             w_flush_now;
    logic             w_d_match;
    logic             w_do_flush;
    logic             w_hit_use;
    logic             w_lookup_miss;
    logic             w_d_accept;
    logic             w_fill_ok;
    logic             w_unused;

    assign w_word      = Core_CacheAddr[2+WordW-1:2];
    assign w_idx       = Core_CacheAddr[2+WordW+IdxW-1:2+WordW];
    assign w_tag       = Core_CacheAddr[31:2+WordW+IdxW];
    assign w_fill_idx  = r_line_addr[IdxW-1:0];
    assign w_fill_tag  = r_line_addr[LineW-1:IdxW];
    assign w_flush_now = Core_CacheFlush | r_flush_pend;
    assign w_d_match   = Bus_dBitsValid && (Bus_dBitsOpcode == 3'd1) &&
                         (Bus_dBitsSource == SOURCE_ID);
    assign w_unused    = ^Core_CacheAddr[1:0];

    // A-channel fields are constant or register-derived, so they stay stable under backpressure
    assign Bus_aBitsAddress = {r_line_addr, r_beat, 2'b00};
    assign Bus_aBitsOpcode  = 3'd4;
    assign Bus_aBitsSize    = 4'd2;
    assign Bus_aBitsMask    = 4'hF;
    assign Bus_aBitsData    = 32'd0;
    assign Bus_aBitsParam   = 3'd0;
    assign Bus_aBitsSource  = SOURCE_ID;
    assign Bus_aBitsCorrupt = 1'b0;

    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = 1'b0;
        w_hit_word = 32'd0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit      = 1'b1;
                w_hit_way  = 1'(w);
                w_hit_word = r_data[w][w_idx][w_word];
            end
        end
    end

    // Lowest-numbered invalid way wins; otherwise the LRU pointer names the victim
    always_comb begin
        w_victim = (WAYS > 1) ? r_lru[w_idx] : 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w][w_idx]) begin
                w_victim = 1'(w);
            end
        end
    end

    always_comb begin
        w_state_d      = r_state;
        Cache_DataRd   = 32'd0;
        Cache_StallReq = 1'b0;
        Cache_Error    = 1'b0;
        Bus_aBitsValid = 1'b0;
        Bus_dBitsReady = 1'b0;
        w_do_flush     = 1'b0;
        w_hit_use      = 1'b0;
        w_lookup_miss  = 1'b0;
        w_d_accept     = 1'b0;
        w_fill_ok      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_flush_now) begin
                    Cache_StallReq = 1'b1;
                    w_do_flush     = 1'b1;
                end else if (Core_CacheEn) begin
                    if (w_hit) begin
                        Cache_DataRd = w_hit_word;
                        w_hit_use    = 1'b1;
                    end else begin
                        Cache_StallReq = 1'b1;
                        w_lookup_miss  = 1'b1;
                        w_state_d      = StReq;
                    end
                end
            end
            StReq: begin
                Cache_StallReq = 1'b1;
                Bus_aBitsValid = 1'b1;
                if (Bus_aBitsReady) begin
                    w_state_d = StResp;
                end
            end
            StResp: begin
                Cache_StallReq = 1'b1;
                Bus_dBitsReady = 1'b1;
                if (w_d_match) begin
                    w_d_accept = 1'b1;
                    w_state_d  = (r_beat == LastBeat) ? StFill : StReq;
                end
            end
            StFill: begin
                if (r_err) begin
                    Cache_Error = 1'b1;
                end else begin
                    Cache_StallReq = 1'b1;
                    w_fill_ok      = 1'b1;
                end
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_lru        <= '0;
            r_flush_pend <= 1'b0;
            r_line_addr  <= '0;
            r_beat       <= '0;
            r_err        <= 1'b0;
            r_victim     <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
            end
        end else begin
            r_state <= w_state_d;
            if (w_do_flush) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[w] <= '0;
                end
                r_lru        <= '0;
                r_flush_pend <= 1'b0;
            end else if ((r_state != StIdle) && Core_CacheFlush) begin
                r_flush_pend <= 1'b1;
            end
            if (w_hit_use && (WAYS > 1)) begin
                r_lru[w_idx] <= ~w_hit_way;
            end
            if (w_lookup_miss) begin
                r_line_addr <= Core_CacheAddr[31:2+WordW];
                r_victim    <= w_victim;
                r_beat      <= '0;
                r_err       <= 1'b0;
            end
            if (w_d_accept) begin
                r_beat <= r_beat + 1'b1;
                r_err  <= r_err | Bus_dBitsDennied | Bus_dBitsCorrupt;
            end
            if (w_fill_ok) begin
                r_valid[r_victim][w_fill_idx] <= 1'b1;
                if (WAYS > 1) begin
                    r_lru[w_fill_idx] <= ~r_victim;
                end
            end
        end
    end

    // Tag and data arrays need no reset: valid bits gate every use
    always_ff @(posedge clk) begin
        if (w_d_accept) begin
            r_buf[r_beat] <= Bus_dBitsData;
        end
        if (w_fill_ok) begin
            r_tag[r_victim][w_fill_idx] <= w_fill_tag;
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_data[r_victim][w_fill_idx][i] <= r_buf[i];
            end
        end
    end

endmodule

// File: tb/tb_l1i_cache_sa.sv
// Bench for l1i_cache_sa: TileLink responder, directed vector table, refill corner cases
// and a randomized fetch stream checked against a recency-list cache model.
module tb_l1i_cache_sa;
    localparam int unsigned Sets = 16;
    localparam int unsigned Ways = 2;
    localparam logic [4:0]  Src  = 5'd0;

    logic        clk;
    logic        rst;
    logic        Core_CacheEn;
    logic [31:0] Core_CacheAddr;
    logic        Core_CacheFlush;
    logic [31:0] Cache_DataRd;
    logic        Cache_StallReq;
    logic        Cache_Error;
    logic        Bus_aBitsReady;
    logic        Bus_aBitsValid;
    logic [31:0] Bus_aBitsAddress;
    logic [2:0]  Bus_aBitsOpcode;
    logic [3:0]  Bus_aBitsSize;
    logic [3:0]  Bus_aBitsMask;
    logic [31:0] Bus_aBitsData;
    logic [2:0]  Bus_aBitsParam;
    logic [4:0]  Bus_aBitsSource;
    logic        Bus_aBitsCorrupt;
    logic        Bus_dBitsReady;
    logic        Bus_dBitsValid;
    logic [2:0]  Bus_dBitsOpcode;
    logic [31:0] Bus_dBitsData;
    logic [4:0]  Bus_dBitsSource;
    logic        Bus_dBitsDennied;
    logic        Bus_dBitsCorrupt;

    int n_checks = 0;
    int n_err    = 0;

    // Responder configuration, written only by the main sequence
    int cfg_a_hold       = 0;
    int cfg_corrupt_beat = -1;
    int cfg_foreign_seq  = 0;
    bit cfg_seq          = 1'b0;
    logic [31:0] a_log[$];

    // Reference cache: per set, line addresses ordered most-recent first
    logic [31:0] mdl_line [Sets][Ways];
    int          mdl_cnt  [Sets];

    typedef struct {
        bit          is_flush;
        logic [31:0] addr;
        int          exp_stalls;
    } vec_t;
    vec_t tbl[11];

    l1i_cache_sa #(
        .WAYS      (2),
        .SETS      (16),
        .LINE_WORDS(4),
        .SOURCE_ID (Src)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .Core_CacheEn    (Core_CacheEn),
        .Core_CacheAddr  (Core_CacheAddr),
        .Core_CacheFlush (Core_CacheFlush),
        .Cache_DataRd    (Cache_DataRd),
        .Cache_StallReq  (Cache_StallReq),
        .Cache_Error     (Cache_Error),
        .Bus_aBitsReady  (Bus_aBitsReady),
        .Bus_aBitsValid  (Bus_aBitsValid),
        .Bus_aBitsAddress(Bus_aBitsAddress),
        .Bus_aBitsOpcode (Bus_aBitsOpcode),
        .Bus_aBitsSize   (Bus_aBitsSize),
        .Bus_aBitsMask   (Bus_aBitsMask),
        .Bus_aBitsData   (Bus_aBitsData),
        .Bus_aBitsParam  (Bus_aBitsParam),
        .Bus_aBitsSource (Bus_aBitsSource),
        .Bus_aBitsCorrupt(Bus_aBitsCorrupt),
        .Bus_dBitsReady  (Bus_dBitsReady),
        .Bus_dBitsValid  (Bus_dBitsValid),
        .Bus_dBitsOpcode (Bus_dBitsOpcode),
        .Bus_dBitsData   (Bus_dBitsData),
        .Bus_dBitsSource (Bus_dBitsSource),
        .Bus_dBitsDennied(Bus_dBitsDennied),
        .Bus_dBitsCorrupt(Bus_dBitsCorrupt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] seq_word(input logic [31:0] a);
        logic [31:0] k;
        k = 32'(a[3:2]) + 32'd1;
        return k * 32'h11;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Bus responder: zero-wait by default, D beat the cycle after each A handshake
    initial begin : responder
        bit          a_fire;
        bit          d_fire;
        bit          outstanding;
        logic [31:0] a_addr_s;
        logic [31:0] out_addr;
        int          hold_cnt;
        int          foreign_served;
        a_fire = 0; d_fire = 0; outstanding = 0; a_addr_s = '0; out_addr = '0;
        hold_cnt = 0; foreign_served = 0;
        Bus_aBitsReady = 1'b0; Bus_dBitsValid = 1'b0; Bus_dBitsOpcode = 3'd1;
        Bus_dBitsData = '0; Bus_dBitsSource = Src; Bus_dBitsDennied = 1'b0;
        Bus_dBitsCorrupt = 1'b0;
        forever begin
            @(negedge clk);
            Bus_dBitsValid   = 1'b0;
            Bus_dBitsOpcode  = 3'd1;
            Bus_dBitsSource  = Src;
            Bus_dBitsData    = '0;
            Bus_dBitsDennied = 1'b0;
            Bus_dBitsCorrupt = 1'b0;
            if (rst) begin
                a_fire = 0; d_fire = 0; outstanding = 0; hold_cnt = 0;
                Bus_aBitsReady = 1'b0;
            end else begin
                if (a_fire) begin
                    outstanding = 1;
                    out_addr    = a_addr_s;
                    a_log.push_back(a_addr_s);
                    hold_cnt    = 0;
                end
                if (d_fire) outstanding = 0;
                if (Bus_aBitsValid && (hold_cnt < cfg_a_hold)) begin
                    Bus_aBitsReady = 1'b0;
                    hold_cnt++;
                end else begin
                    Bus_aBitsReady = 1'b1;
                end
                if (outstanding) begin
                    Bus_dBitsValid = 1'b1;
                    if (foreign_served < cfg_foreign_seq) begin
                        Bus_dBitsSource  = 5'd7;
                        Bus_dBitsData    = 32'hDEAD_BEEF;
                        Bus_dBitsCorrupt = 1'b1;
                        foreign_served++;
                    end else begin
                        Bus_dBitsData    = cfg_seq ? seq_word(out_addr) : mem_word(out_addr);
                        Bus_dBitsCorrupt = (int'(out_addr[3:2]) == cfg_corrupt_beat);
                    end
                end
                #1;
                a_fire   = Bus_aBitsValid && Bus_aBitsReady;
                a_addr_s = Bus_aBitsAddress;
                d_fire   = Bus_dBitsValid && Bus_dBitsReady && (Bus_dBitsSource == Src) &&
                           (Bus_dBitsOpcode == 3'd1);
            end
        end
    end

    // Called at a falling edge; returns at a falling edge with the fetch deasserted
    task automatic do_fetch(input logic [31:0] addr, input bit flush_in_resp,
                            output int stalls, output logic [31:0] data, output logic err);
        bit flushed;
        flushed = 0;
        stalls  = 0;
        Core_CacheEn   = 1'b1;
        Core_CacheAddr = addr;
        #1;
        while (Cache_StallReq && stalls < 300) begin
            stalls++;
            @(negedge clk);
            Core_CacheFlush = 1'b0;
            #1;
            if (flush_in_resp && !flushed && Bus_dBitsReady) begin
                Core_CacheFlush = 1'b1;
                flushed = 1;
            end
        end
        data = Cache_DataRd;
        err  = Cache_Error;
        @(negedge clk);
        Core_CacheEn    = 1'b0;
        Core_CacheFlush = 1'b0;
    endtask

    task automatic do_flush(input string name);
        Core_CacheFlush = 1'b1;
        Core_CacheEn    = 1'b1;
        Core_CacheAddr  = 32'h40;
        #1;
        check({name, "_stall"}, 32'(Cache_StallReq), 32'd1);
        check({name, "_data"}, Cache_DataRd, 32'd0);
        @(negedge clk);
        Core_CacheFlush = 1'b0;
        Core_CacheEn    = 1'b0;
    endtask

    task automatic mdl_clear();
        for (int s = 0; s < Sets; s++) mdl_cnt[s] = 0;
    endtask

    task automatic mdl_access(input logic [31:0] addr, output bit hit);
        logic [31:0] line;
        int s;
        int pos;
        line = addr >> 4;
        s    = int'(line % Sets);
        pos  = -1;
        for (int i = 0; i < mdl_cnt[s]; i++) if (mdl_line[s][i] == line) pos = i;
        hit = (pos >= 0);
        if (!hit) begin
            if (mdl_cnt[s] < Ways) mdl_cnt[s]++;
            pos = mdl_cnt[s] - 1;
        end
        for (int i = pos; i > 0; i--) mdl_line[s][i] = mdl_line[s][i-1];
        mdl_line[s][0] = line;
    endtask

    initial begin : main
        int          st;
        logic [31:0] d;
        logic        e;
        int          sz0;
        bit          found;
        bit          hit;
        logic [31:0] ra;
        int          op;

        tbl[0]  = '{1'b1, 32'h0000_0000, 0};
        tbl[1]  = '{1'b0, 32'h0000_0000, 10};
        tbl[2]  = '{1'b0, 32'h0000_0100, 10};
        tbl[3]  = '{1'b0, 32'h0000_0008, 0};
        tbl[4]  = '{1'b0, 32'h0000_0200, 10};
        tbl[5]  = '{1'b0, 32'h0000_0004, 0};
        tbl[6]  = '{1'b0, 32'h0000_0104, 10};
        tbl[7]  = '{1'b0, 32'h0000_0044, 10};
        tbl[8]  = '{1'b0, 32'h0000_004C, 0};
        tbl[9]  = '{1'b1, 32'h0000_0000, 0};
        tbl[10] = '{1'b0, 32'h0000_0044, 10};

        rst = 1'b1; Core_CacheEn = 1'b0; Core_CacheAddr = '0; Core_CacheFlush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", 32'(Cache_StallReq), 32'd0);
        check("rst_data", Cache_DataRd, 32'd0);
        check("rst_avalid", 32'(Bus_aBitsValid), 32'd0);
        check("rst_dready", 32'(Bus_dBitsReady), 32'd0);
        check("rst_error", 32'(Cache_Error), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Cold miss with sequential bus data
        cfg_seq = 1'b1;
        sz0 = a_log.size();
        do_fetch(32'h44, 0, st, d, e);
        check("cold_stalls", st, 10);
        check("cold_data", d, 32'h22);
        check("cold_alog_len", a_log.size() - sz0, 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("cold_aaddr%0d", k), a_log[sz0+k], 32'h40 + 32'(4*k));
        do_fetch(32'h4C, 0, st, d, e);
        check("cold_hit_stalls", st, 0);
        check("cold_hit_data", d, 32'h44);
        cfg_seq = 1'b0;
        #1;
        check("idle_stall", 32'(Cache_StallReq), 32'd0);
        check("idle_data", Cache_DataRd, 32'd0);
        @(negedge clk);

        do_flush("idleflush");
        do_fetch(32'h40, 0, st, d, e);
        check("postflush_stalls", st, 10);
        check("postflush_data", d, mem_word(32'h40));

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].is_flush) begin
                do_flush($sformatf("tbl%0d", i));
            end else begin
                do_fetch(tbl[i].addr, 0, st, d, e);
                check($sformatf("tbl%0d_stalls", i), st, tbl[i].exp_stalls);
                check($sformatf("tbl%0d_data", i), d, mem_word(tbl[i].addr));
                check($sformatf("tbl%0d_err", i), 32'(e), 32'd0);
            end
        end

        // Flush during RESP: line filled, then invalidated, then refetched
        do_fetch(32'h244, 1, st, d, e);
        check("respflush_stalls", st, 21);
        check("respflush_data", d, mem_word(32'h244));

        // Corrupt beat 2: all beats collected, one-cycle error, nothing installed
        cfg_corrupt_beat = 2;
        sz0 = a_log.size();
        do_fetch(32'hF08, 0, st, d, e);
        check("corrupt_stalls", st, 9);
        check("corrupt_err", 32'(e), 32'd1);
        check("corrupt_data", d, 32'd0);
        check("corrupt_alog_len", a_log.size() - sz0, 4);
        #1;
        check("corrupt_err_width", 32'(Cache_Error), 32'd0);
        cfg_corrupt_beat = -1;
        do_fetch(32'hF08, 0, st, d, e);
        check("corrupt_retry_stalls", st, 10);
        check("corrupt_retry_data", d, mem_word(32'hF08));

        // A-channel backpressure of 3 cycles on every beat
        cfg_a_hold = 3;
        Core_CacheEn = 1'b1; Core_CacheAddr = 32'hD04; st = 0;
        #1;
        while (Cache_StallReq && st < 300) begin
            st++;
            @(negedge clk);
            #1;
            if (st >= 1 && st <= 3) begin
                check($sformatf("bp_valid%0d", st), 32'(Bus_aBitsValid), 32'd1);
                check($sformatf("bp_addr%0d", st), Bus_aBitsAddress, 32'hD00);
                check($sformatf("bp_opcode%0d", st), 32'(Bus_aBitsOpcode), 32'd4);
            end
        end
        check("bp_stalls", st, 22);
        check("bp_data", Cache_DataRd, mem_word(32'hD04));
        @(negedge clk);
        Core_CacheEn = 1'b0;
        cfg_a_hold = 0;

        // Foreign-source D beat ignored
        cfg_foreign_seq++;
        sz0 = a_log.size();
        do_fetch(32'hE0C, 0, st, d, e);
        check("foreign_stalls", st, 11);
        check("foreign_data", d, mem_word(32'hE0C));
        check("foreign_err", 32'(e), 32'd0);
        check("foreign_alog_len", a_log.size() - sz0, 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("foreign_aaddr%0d", k), a_log[sz0+k], 32'hE00 + 32'(4*k));

        // Reset during beat 1 of a refill
        do_fetch(32'hC0, 0, st, d, e);
        check("prerst_fill_stalls", st, 10);
        Core_CacheEn = 1'b1; Core_CacheAddr = 32'h84; found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            #1;
            if (Bus_dBitsReady && Bus_aBitsAddress == 32'h84) found = 1;
        end
        check("midrst_reached_beat1", 32'(found), 32'd1);
        Core_CacheEn = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_stall", 32'(Cache_StallReq), 32'd0);
        check("midrst_avalid", 32'(Bus_aBitsValid), 32'd0);
        check("midrst_dready", 32'(Bus_dBitsReady), 32'd0);
        check("midrst_error", 32'(Cache_Error), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_fetch(32'h84, 0, st, d, e);
        check("postrst_miss_stalls", st, 10);
        check("postrst_data", d, mem_word(32'h84));
        do_fetch(32'hC0, 0, st, d, e);
        check("postrst_cleared_stalls", st, 10);

        // Randomized fetch stream against the recency-list model
        do_flush("rnd_init");
        mdl_clear();
        for (int n = 0; n < 80; n++) begin
            op = int'($urandom_range(0, 19));
            if (op == 0) begin
                Core_CacheEn = 1'b0;
                #1;
                check($sformatf("rnd%0d_idle_stall", n), 32'(Cache_StallReq), 32'd0);
                check($sformatf("rnd%0d_idle_data", n), Cache_DataRd, 32'd0);
                @(negedge clk);
            end else if (op <= 2) begin
                do_flush($sformatf("rnd%0d_flush", n));
                mdl_clear();
            end else begin
                ra = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 2)) << 4) |
                     (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
                mdl_access(ra, hit);
                do_fetch(ra, 0, st, d, e);
                check($sformatf("rnd%0d_stalls_%h", n, ra), st, hit ? 0 : 10);
                check($sformatf("rnd%0d_data_%h", n, ra), d, mem_word(ra));
                check($sformatf("rnd%0d_err", n), 32'(e), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
